atsc_pilot_upconv: RTL

Transmit-side counterpart of the ATSC RX frequency/pilot-locked loop: takes real 8-VSB symbols and produces a complex sc16 baseband stream.

- Adds the DC pilot and rotates the signal by a programmable NCO frequency offset.
- Produces test signals for the RX FPLL, and serves as the TX upconversion stage.
- Sits between the `axi_wrapper` master/slave AXI-stream ports inside its own RFNoC block.
- `phase_inc` and `pilot_level` are driven from user settings registers 128 and 129.

---
 rtl/atsc_pilot_upconv.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/atsc_pilot_upconv.sv
// atsc_pilot_upconv: real 8-VSB symbols -> complex sc16 baseband.
// Adds a DC pilot, then rotates by a programmable NCO. Config is shadowed
// and only becomes active between packets.
// Optional feature macro: ATSC_PILOT_UPCONV_PILOT_EN (pilot add + saturation).
// Pipeline: accept/pilot -> sine ROM -> mix/round, 3 cycles, global stall.
module atsc_pilot_upconv #(
    parameter int unsigned LUT_AW = 10
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [31:0] phase_inc,
    input  logic [15:0] pilot_level,
    input  logic        cfg_stb,
    input  logic [31:0] in_TDATA,
    input  logic        in_TVALID,
    output logic        in_TREADY,
    input  logic        in_TLAST,
    output logic [31:0] out_TDATA,
    output logic        out_TVALID,
    input  logic        out_TREADY,
    output logic        out_TLAST
);

    localparam int unsigned       ROM_N = 2 ** LUT_AW;
    localparam real               PI    = 3.14159265358979323846;
    localparam logic [LUT_AW-1:0] QTR   = LUT_AW'(ROM_N / 4);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    // Sine table entry, rounded to nearest; evaluated with constant arguments only.
    function automatic logic signed [15:0] rom_val(input int unsigned k);
        real a;
        a = 32767.0 * $sin(2.0 * PI * real'(k) / real'(ROM_N));
        return 16'($rtoi((a >= 0.0) ? $floor(a + 0.5) : $ceil(a - 0.5)));
    endfunction

    // (p + 2^14) >>> 15 with saturation to the signed 16-bit range.
    function automatic logic signed [15:0] round_sat(input logic signed [31:0] p);
        logic signed [32:0] r;
        r = ($signed({p[31], p}) + 33'sd16384) >>> 15;
        if (r > 33'sd32767) begin
            return 16'sh7fff;
        end else if (r < -33'sd32768) begin
            return 16'sh8000;
        end else begin
            return r[15:0];
        end
    endfunction

    logic signed [15:0] rom [ROM_N];

    for (genvar g = 0; g < ROM_N; g++) begin : g_rom
        assign rom[g] = rom_val(g);
    end

    state_t             state;
    logic [31:0]        acc;
    logic [31:0]        sh_inc;
    logic [31:0]        act_inc;
    logic [31:0]        sh_inc_nxt;
    logic               en;
    logic               accept;
    logic               act_load;
    logic signed [15:0] x_in;
    logic signed [15:0] s_in;

    logic                    s0_valid;
    logic                    s0_last;
    logic signed [15:0]      s0_s;
    logic [LUT_AW-1:0]       s0_k;
    logic [LUT_AW-1:0]       s0_kc;
    logic                    s1_valid;
    logic                    s1_last;
    logic signed [15:0]      s1_s;
    logic signed [15:0]      s1_sin;
    logic signed [15:0]      s1_cos;
    logic signed [15:0]      mix_i;
    logic signed [15:0]      mix_q;
    logic                    unused_bits;

`ifdef ATSC_PILOT_UPCONV_PILOT_EN
    logic signed [15:0] sh_pilot;
    logic signed [15:0] act_pilot;
    logic signed [15:0] sh_pilot_nxt;
    logic signed [16:0] pil_sum;
`endif

    assign en         = !out_TVALID || out_TREADY;
    assign in_TREADY  = en && ap_rst_n;
    assign accept     = in_TVALID && in_TREADY;
    assign x_in       = in_TDATA[15:0];
    assign sh_inc_nxt = cfg_stb ? phase_inc : sh_inc;
    assign s0_kc      = s0_k + QTR;
    // Active config follows the shadow whenever the machine is (or is returning to) idle;
    // using the next-shadow value lets a strobe coincident with TLAST reach the next packet.
    assign act_load   = accept ? in_TLAST : (state == IDLE);

`ifdef ATSC_PILOT_UPCONV_PILOT_EN
    assign sh_pilot_nxt = cfg_stb ? pilot_level : sh_pilot;
    assign unused_bits  = ^in_TDATA[31:16];

    // Stage 0 pilot add with 17-bit sum clipped back to 16 bits.
    always_comb begin
        pil_sum = {x_in[15], x_in} + {act_pilot[15], act_pilot};
        s_in    = pil_sum[15:0];
        if (pil_sum[16] != pil_sum[15]) begin
            s_in = pil_sum[16] ? 16'sh8000 : 16'sh7fff;
        end
    end
`else
    assign unused_bits = ^{in_TDATA[31:16], pilot_level};

    // Without the pilot feature the symbol passes straight through.
    always_comb begin
        s_in = x_in;
    end
`endif

    // Packet FSM, phase accumulator and shadow/active config registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            sh_inc    <= '0;
            act_inc   <= '0;
`ifdef ATSC_PILOT_UPCONV_PILOT_EN
            sh_pilot  <= '0;
            act_pilot <= '0;
`endif
        end else begin
            sh_inc <= sh_inc_nxt;
`ifdef ATSC_PILOT_UPCONV_PILOT_EN
            sh_pilot <= sh_pilot_nxt;
            if (act_load) begin
                act_pilot <= sh_pilot_nxt;
            end
`endif
            if (act_load) begin
                act_inc <= sh_inc_nxt;
            end
            if (accept) begin
                acc <= acc + act_inc;
                case (state)
                    IDLE:    if (!in_TLAST) state <= IN_PKT;
                    IN_PKT:  if (in_TLAST)  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stage 2 combinational mix ahead of the output register.
    always_comb begin
        mix_i = round_sat(32'(s1_s) * 32'(s1_cos));
        mix_q = round_sat(32'(s1_s) * 32'(s1_sin));
    end

    // Three-stage data pipeline; every stage moves together when en is high.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s0_valid   <= 1'b0;
            s0_last    <= 1'b0;
            s0_s       <= '0;
            s0_k       <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_s       <= '0;
            s1_sin     <= '0;
            s1_cos     <= '0;
            out_TVALID <= 1'b0;
            out_TLAST  <= 1'b0;
            out_TDATA  <= '0;
        end else if (en) begin
            s0_valid   <= accept;
            s0_last    <= in_TLAST;
            s0_s       <= s_in;
            s0_k       <= acc[31 -: LUT_AW];
            s1_valid   <= s0_valid;
            s1_last    <= s0_last;
            s1_s       <= s0_s;
            s1_sin     <= rom[s0_k];
            s1_cos     <= rom[s0_kc];
            out_TVALID <= s1_valid;
            out_TLAST  <= s1_last;
            out_TDATA  <= {mix_i, mix_q};
        end
    end

endmodule
